// File: rtl/line_encoder_if.sv
// Request/offer bundle for line_encoder: eight request lines in, encoded event handshake out.
interface line_encoder_if;
   logic       x0, x1, x2, x3, x4, x5, x6, x7;
   logic       ack;
   logic       clr_ovf;
   logic [2:0] num;
   logic       valid;
   logic [7:0] pending;
   logic       overflow;

   modport master (
      output x0, x1, x2, x3, x4, x5, x6, x7, ack, clr_ovf,
      input  num, valid, pending, overflow
   );

   modport slave (
      input  x0, x1, x2, x3, x4, x5, x6, x7, ack, clr_ovf,
      output num, valid, pending, overflow
   );
endinterface

// File: rtl/line_encoder.sv
// 8-to-3 event encoder: captures request-line events into a pending register and offers one at a time.
// Define LINE_ENCODER_ROUND_ROBIN_EN for round-robin selection instead of fixed highest-index priority.
module line_encoder #(
   parameter int EDGE_MODE = 1
) (
   input  logic           clk,
   input  logic           reset,
   line_encoder_if.slave  bus
);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t     state_q, state_d;
   logic [7:0] x_vec, x_q;
   logic [7:0] ev, clr;
   logic [7:0] pending_q, pending_d;
   logic [2:0] num_q, num_d;
   logic       ovf_q, ovf_d, ovf_set;
   logic [2:0] sel_idx;
   logic       sel_any;
`ifdef LINE_ENCODER_ROUND_ROBIN_EN
   logic [2:0] last_q, last_d;
   logic [2:0] cand;
`endif

   assign x_vec = {bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};

   always_comb begin
      ev = (EDGE_MODE != 0) ? (x_vec & ~x_q) : x_vec;
      clr = '0;
      if (state_q == OFFER && bus.ack) clr[num_q] = 1'b1;
      pending_d = (pending_q & ~clr) | ev;
      // A fresh edge on the line being acknowledged this cycle is a new event, not a lost one.
      ovf_set = (EDGE_MODE != 0) && (|(ev & pending_q & ~clr));
      if (ovf_set)          ovf_d = 1'b1;
      else if (bus.clr_ovf) ovf_d = 1'b0;
      else                  ovf_d = ovf_q;
   end

   // Scan from lowest to highest priority so the last hit wins.
   always_comb begin
      sel_idx = '0;
      sel_any = |pending_q;
`ifdef LINE_ENCODER_ROUND_ROBIN_EN
      cand = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         cand = last_q + 3'(k);
         if (pending_q[cand]) sel_idx = cand;
      end
`else
      for (int unsigned k = 0; k < 8; k++) begin
         if (pending_q[k]) sel_idx = 3'(k);
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
`ifdef LINE_ENCODER_ROUND_ROBIN_EN
      last_d  = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (sel_any) begin
               num_d   = sel_idx;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (bus.ack) begin
               state_d = IDLE;
`ifdef LINE_ENCODER_ROUND_ROBIN_EN
               last_d  = num_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         x_q       <= '0;
         pending_q <= '0;
         num_q     <= '0;
         ovf_q     <= 1'b0;
`ifdef LINE_ENCODER_ROUND_ROBIN_EN
         last_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         x_q       <= x_vec;
         pending_q <= pending_d;
         num_q     <= num_d;
         ovf_q     <= ovf_d;
`ifdef LINE_ENCODER_ROUND_ROBIN_EN
         last_q    <= last_d;
`endif
      end
   end

   assign bus.num      = num_q;
   assign bus.valid    = (state_q == OFFER);
   assign bus.pending  = pending_q;
   assign bus.overflow = ovf_q;

endmodule

// File: doc/line_encoder.md
Name: line_encoder

Overview:
- 8-to-3 event encoder; the inverse of the 3-8 line decoder.
- Captures events on 8 individual request lines into a pending register.
- Selects one pending line by priority and presents its 3-bit number with a valid/ack handshake.
- Used by the CPU/monitor side to turn discrete request lines back into a `num` code, one event at a time.

Parameters:
- EDGE_MODE, 1, 1 = `pending[i]` set on rising edge of `x<i>`; 0 = `pending[i]` set on every cycle `x<i>` is high (level mode).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- x0..x7  input  1 each  request lines; synchronous to `clk`
- ack  input  1  consumer accepts current `num`; meaningful only while `valid`=1
- clr_ovf  input  1  clears the `overflow` flag
- num  output  3  encoded line number of the event being offered
- valid  output  1  `num` holds an event awaiting `ack`
- pending  output  8  captured, not-yet-acknowledged events; bit i = line i
- overflow  output  1  sticky flag: an event was lost

Behaviour:
- Reset (synchronous, `reset`=1 at clock edge):
  - state=IDLE; `num`=0, `valid`=0, `pending`=0, `overflow`=0.
  - Edge-detect register `x_d`=0, so a line already high when reset deasserts counts as one edge in the first cycle.
  - Reset mid-offer drops the offer and all pending events.
- Event detect:
  - ev[i] = `x<i>` & ~`x_d[i]` (EDGE_MODE=1), or ev[i] = `x<i>` (EDGE_MODE=0).
  - `x_d` <= {x7..x0} every cycle.
- Pending update each cycle: `pending[i]` <= (`pending[i]` & ~clr[i]) | ev[i].
  - clr[i] = (state==OFFER & `ack` & `num`==i).
  - A new event on the line being acknowledged in the same cycle leaves the bit set; it is a new event, not an overflow.
- Overflow:
  - EDGE_MODE=1: set when ev[i] & `pending[i]` & ~clr[i] for any i.
  - EDGE_MODE=0: never set.
  - Cleared by `clr_ovf`. Set takes precedence over a simultaneous clear.
- FSM:
  - IDLE, `pending`!=0: `num` <= selected index, `valid` <= 1, go to OFFER. Selection uses the registered `pending` value, not this cycle's ev.
  - IDLE, `pending`==0: hold; `num` keeps its last value, `valid`=0.
  - OFFER, `ack`=0: hold; `num` and `valid` stable; later higher-priority events do not preempt.
  - OFFER, `ack`=1: `valid` <= 0, go to IDLE.
- Priority (default): highest index wins (7 > 6 > ... > 0).
- Latency:
  - Edge sampled at clock edge E0 sets `pending` at E0.
  - `valid`=1 after E1 (2 edges).
  - After `ack`, at least one IDLE cycle, so consecutive offers are at least 2 cycles apart.
- `ack` while `valid`=0 is ignored.

Optional Feature:
- Macro `LINE_ENCODER_ROUND_ROBIN_EN`.
- Defined:
  - Adds a 3-bit `last` register, reset 0, updated to `num` on each accepted `ack`.
  - Search order is (last+7)%8, (last+6)%8, ..., last. The first pending bit found wins.
  - After reset the order is 7..0, identical to fixed priority.
- Undefined: fixed priority, no `last` register.

Test Plan:
- Single event: pulse `x3` for 1 cycle -> `pending`=8'h08 at next edge, then `valid`=1, `num`=3. Hold `ack`=0 for 5 cycles -> `num`=3 stable. `ack`=1 -> `valid`=0, `pending`=0.
- Multiple events: pulse `x1`, `x5`, `x6` together, ack each offer immediately -> offers `num`=6, 5, 1 in order. `valid` low for 1 cycle between offers. `pending` ends at 0.
- Overflow/same-cycle edge (EDGE_MODE=1):
  - Two `x2` pulses before any `ack` -> `overflow`=1, only one offer of `num`=2.
  - `x2` edge in the same cycle as `ack` of `num`=2 -> `pending[2]` stays 1, `overflow` stays 0, second offer `num`=2.
  - `clr_ovf` -> `overflow`=0.
- No preemption: while offering `num`=2, raise `x7` -> `num` stays 2 until `ack`, then next offer `num`=7.
- Reset mid-offer: `valid`=1, `num`=4, `pending`=8'h90, assert `reset` 1 cycle -> `valid`=0, `num`=0, `pending`=0, `overflow`=0. A line held high through reset produces exactly one offer.
- Round-robin (macro defined): keep `x0` and `x7` pulsing every 4 cycles, ack immediately -> offers alternate 7, 0, 7, 0. With macro undefined -> 7 always wins while `pending[7]`=1.
